// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory arbiter.
//               owner_e         - previous-cycle winner (IDLE/CPU/EXT)
//               WORD            - default address/data width
//               STARVE_CNT_W    - width of the ext starvation counter
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int WORD         = 16;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        EXT  = 2'd2
    } owner_e;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundle of the cpu and ext requester ports, the registered
//               memory command and the read-data return path.
//               slave  - arbiter view (requests in, grants/command out)
//               master - environment view (requesters and memory)
//               starve_cnt exposes the ext starvation counter for observation.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int AW = WORD,
    parameter int DW = WORD
);
    // cpu requester
    logic                    cpu_req;
    logic                    cpu_we;
    logic [AW-1:0]           cpu_addr;
    logic [DW-1:0]           cpu_wdata;
    logic                    cpu_lock;
    logic                    cpu_gnt;
    logic                    cpu_rvalid;
    logic [DW-1:0]           cpu_rdata;
    // ext requester
    logic                    ext_req;
    logic                    ext_we;
    logic [AW-1:0]           ext_addr;
    logic [DW-1:0]           ext_wdata;
    logic                    ext_gnt;
    logic                    ext_rvalid;
    logic [DW-1:0]           ext_rdata;
    logic                    ext_starved;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    // memory side
    logic                    mem_en;
    logic                    mem_we;
    logic [AW-1:0]           mem_addr;
    logic [DW-1:0]           mem_wdata;
    logic [DW-1:0]           mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output ext_gnt, ext_rvalid, ext_rdata, ext_starved, starve_cnt,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  ext_gnt, ext_rvalid, ext_rdata, ext_starved, starve_cnt,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/dmem_arb_starve.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_starve
// Description : Saturating count of consecutive cycles in which ext requested
//               but was not granted. Cleared by an ext grant or by ext
//               dropping its request.
// Ports       : clk, reset (async, active-low)
//               i_ext_req, i_ext_gnt  - ext request / grant this cycle
//               o_starve_cnt          - current count
//               o_at_limit            - count has reached STARVE_LIMIT
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_starve
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    i_ext_req,
    input  wire logic                    i_ext_gnt,
    output logic [STARVE_CNT_W-1:0]      o_starve_cnt,
    output logic                         o_at_limit
);

    localparam logic [STARVE_CNT_W-1:0] c_LIMIT = STARVE_CNT_W'(STARVE_LIMIT);
    localparam logic [STARVE_CNT_W-1:0] c_ONE   = STARVE_CNT_W'(1);

    logic [STARVE_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!i_ext_req || i_ext_gnt) begin
            r_cnt <= '0;
        end else if (r_cnt != c_LIMIT) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign o_starve_cnt = r_cnt;
    assign o_at_limit   = (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Per-cycle arbiter sharing a single-port sync-read data memory
//               between the cpu load/store stage and an ext loader/debug
//               master. cpu has fixed priority; ext wins once it has been
//               denied STARVE_LIMIT consecutive cycles. The memory command is
//               registered (grant cycle N -> mem_* at N+1) and load data is
//               returned to the winner at N+2.
// Ports       : clk, reset (async, active-low), bus (dmem_arbiter_if.slave)
// Config      : DMEM_ARB_LOCK_EN - when defined, cpu_lock held by the current
//               cpu owner blocks every ext grant, including the override.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = WORD,
    parameter int DW           = WORD,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    dmem_arbiter_if.slave bus
);

    owner_e                  r_owner;
    owner_e                  w_owner_nxt;
    logic                    w_lock_active;
    logic                    w_at_limit;
    logic [STARVE_CNT_W-1:0] w_starve_cnt;
    logic                    w_ext_starved;
    logic                    w_cpu_gnt;
    logic                    w_ext_gnt;
    logic                    w_any_gnt;
    logic                    w_win_we;

    logic                    r_mem_en;
    logic                    r_mem_we;
    logic [AW-1:0]           r_mem_addr;
    logic [DW-1:0]           r_mem_wdata;
    // Read tag pipeline: stage 1 travels with the memory command,
    // stage 2 marks the cycle the sync-read data is on mem_rdata.
    logic                    r_rd1_v;
    logic                    r_rd1_ext;
    logic                    r_rd2_v;
    logic                    r_rd2_ext;

    dmem_arb_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk          (clk),
        .reset        (reset),
        .i_ext_req    (bus.ext_req),
        .i_ext_gnt    (w_ext_gnt),
        .o_starve_cnt (w_starve_cnt),
        .o_at_limit   (w_at_limit)
    );

    // ---------------- owner FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner <= IDLE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // ---------------- owner FSM: next state ----------------
    always_comb begin
        w_owner_nxt = IDLE;
        if (w_cpu_gnt) begin
            w_owner_nxt = CPU;
        end else if (w_ext_gnt) begin
            w_owner_nxt = EXT;
        end
    end

    // ---------------- owner FSM: outputs ----------------
    always_comb begin
        w_lock_active = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        w_lock_active = (r_owner == CPU) && bus.cpu_lock;
`else
        // Lock feature absent: ownership is tracked but never gates ext.
        w_lock_active = 1'b0 & (r_owner == CPU) & bus.cpu_lock;
`endif
    end

    // ---------------- grant logic ----------------
    // Grants are forced low while reset is asserted.
    always_comb begin
        w_ext_starved = reset && w_at_limit && bus.ext_req && !w_lock_active;
        w_cpu_gnt     = reset && bus.cpu_req && !w_ext_starved;
        w_ext_gnt     = w_ext_starved ||
                        (reset && bus.ext_req && !bus.cpu_req && !w_lock_active);
        w_any_gnt     = w_cpu_gnt || w_ext_gnt;
        w_win_we      = w_cpu_gnt ? bus.cpu_we : bus.ext_we;
    end

    // ---------------- command registers and read tags ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd1_v     <= 1'b0;
            r_rd1_ext   <= 1'b0;
            r_rd2_v     <= 1'b0;
            r_rd2_ext   <= 1'b0;
        end else begin
            r_mem_en <= w_any_gnt;
            if (w_cpu_gnt) begin
                r_mem_we    <= bus.cpu_we;
                r_mem_addr  <= bus.cpu_addr;
                r_mem_wdata <= bus.cpu_wdata;
            end else if (w_ext_gnt) begin
                r_mem_we    <= bus.ext_we;
                r_mem_addr  <= bus.ext_addr;
                r_mem_wdata <= bus.ext_wdata;
            end
            r_rd1_v   <= w_any_gnt && !w_win_we;
            r_rd1_ext <= w_ext_gnt;
            r_rd2_v   <= r_rd1_v;
            r_rd2_ext <= r_rd1_ext;
        end
    end

    assign bus.cpu_gnt     = w_cpu_gnt;
    assign bus.ext_gnt     = w_ext_gnt;
    assign bus.ext_starved = w_ext_starved;
    assign bus.starve_cnt  = w_starve_cnt;
    assign bus.cpu_rvalid  = r_rd2_v && !r_rd2_ext;
    assign bus.ext_rvalid  = r_rd2_v && r_rd2_ext;
    assign bus.cpu_rdata   = bus.mem_rdata;
    assign bus.ext_rdata   = bus.mem_rdata;
    assign bus.mem_en      = r_mem_en;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. A transaction-level
//               reference model (in-order memory array, starvation count,
//               expected-return queue) predicts every output each cycle.
//               Directed scenarios are followed by a randomized phase.
// Config      : DMEM_ARB_LOCK_EN selects the lock-enabled expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic clk;
    logic reset;

    dmem_arbiter_if #(.AW(16), .DW(16)) bus ();

    dmem_arbiter #(
        .AW           (16),
        .DW           (16),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory array behind the arbiter (sync read, write on mem_en&&mem_we)
    logic [15:0] tb_mem [0:65535];
    logic [15:0] mem_rd;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
            else            mem_rd <= tb_mem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = mem_rd;

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [0:65535];
    int          m_sc;
    int          m_owner;          // 0 none, 1 cpu, 2 ext (previous winner)
    bit          m_en, m_we;
    logic [15:0] m_addr, m_wdata;
    // outstanding load returns: {is_ext}, oldest first, with due-cycle tags
    bit          q_v  [2];
    bit          q_x  [2];
    logic [15:0] ret_d;
    bit          ret_v, ret_x;

    int n_err;
    int n_checks;

    // last sampled values for directed literal checks
    logic        s_cgnt, s_egnt, s_st, s_crv, s_erv, s_men, s_mwe;
    logic [15:0] s_crd;
    logic [3:0]  s_sc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sc = 0; m_owner = 0;
        m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        q_v[0] = 0; q_v[1] = 0; q_x[0] = 0; q_x[1] = 0;
        ret_v = 0; ret_x = 0; ret_d = '0;
    endtask

    // One cycle: called at a negedge with inputs already applied.
    task automatic run_cycle();
        bit lk, est, ecg, eeg, wwe;
        logic [15:0] rd;
        #1;
        lk = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        lk = (m_owner == 1) && bus.cpu_lock;
`endif
        est = 0; ecg = 0; eeg = 0;
        if (reset) begin
            est = (m_sc == LIMIT) && bus.ext_req && !lk;
            ecg = bus.cpu_req && !est;
            eeg = est || (bus.ext_req && !bus.cpu_req && !lk);
        end
        s_cgnt = bus.cpu_gnt;  s_egnt = bus.ext_gnt;  s_st = bus.ext_starved;
        s_crv  = bus.cpu_rvalid; s_erv = bus.ext_rvalid; s_crd = bus.cpu_rdata;
        s_men  = bus.mem_en;   s_mwe = bus.mem_we;    s_sc = bus.starve_cnt;
        chk("cpu_gnt",     bus.cpu_gnt,     ecg);
        chk("ext_gnt",     bus.ext_gnt,     eeg);
        chk("ext_starved", bus.ext_starved, est);
        chk("starve_cnt",  bus.starve_cnt,  m_sc);
        chk("mem_en",      bus.mem_en,      m_en);
        chk("mem_we",      bus.mem_we,      m_we);
        chk("mem_addr",    bus.mem_addr,    m_addr);
        chk("mem_wdata",   bus.mem_wdata,   m_wdata);
        chk("cpu_rvalid",  bus.cpu_rvalid,  ret_v && !ret_x);
        chk("ext_rvalid",  bus.ext_rvalid,  ret_v && ret_x);
        if (ret_v && !ret_x) chk("cpu_rdata", bus.cpu_rdata, ret_d);
        if (ret_v &&  ret_x) chk("ext_rdata", bus.ext_rdata, ret_d);

        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            // memory executes the command issued last cycle
            rd = '0;
            if (m_en) begin
                if (m_we) ref_mem[m_addr] = m_wdata;
                else      rd = ref_mem[m_addr];
            end
            // a load's data returns one cycle after its command executes
            ret_v = q_v[0] && m_en && !m_we;
            ret_x = q_x[0];
            ret_d = rd;
            wwe   = ecg ? bus.cpu_we : bus.ext_we;
            q_v[0] = (ecg || eeg) && !wwe;
            q_x[0] = eeg;
            // starvation count
            if (bus.ext_req && !eeg) m_sc = (m_sc < LIMIT) ? m_sc + 1 : LIMIT;
            else                     m_sc = 0;
            m_owner = ecg ? 1 : (eeg ? 2 : 0);
            m_en = ecg || eeg;
            if (ecg) begin
                m_we = bus.cpu_we; m_addr = bus.cpu_addr; m_wdata = bus.cpu_wdata;
            end else if (eeg) begin
                m_we = bus.ext_we; m_addr = bus.ext_addr; m_wdata = bus.ext_wdata;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_lock = 0;
        bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = '0; bus.ext_wdata = '0;
    endtask

    initial begin
        int first_egnt;
        int egnt_cnt;
        int st_cnt;
        n_err = 0; n_checks = 0;
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 65536; i++) begin
            tb_mem[i]  = 16'(i) ^ 16'hA5A5;
            ref_mem[i] = 16'(i) ^ 16'hA5A5;
        end
        tb_mem[16'h0010]  = 16'hBEEF;
        ref_mem[16'h0010] = 16'hBEEF;
        model_reset();

        // ---- reset state ----
        @(negedge clk);
        run_cycle();
        run_cycle();
        chk("rst_mem_en", s_men, 1'b0);
        reset = 1'b1;
        run_cycle();

        // ---- cpu load from 0x0010 ----
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0010;
        run_cycle();
        chk("t1_gnt", s_cgnt, 1'b1);
        idle_inputs();
        run_cycle();
        chk("t1_mem_en", s_men, 1'b1);
        run_cycle();
        chk("t1_rvalid", s_crv, 1'b1);
        chk("t1_rdata",  s_crd, 16'hBEEF);
        run_cycle();

        // ---- continuous contention ----
        bus.cpu_req = 1; bus.cpu_addr = 16'h0030;
        bus.ext_req = 1; bus.ext_addr = 16'h0031;
        for (int i = 0; i < LIMIT; i++) begin
            run_cycle();
            chk("t2_cpu_wins", s_cgnt, 1'b1);
        end
        run_cycle();
        chk("t2_starved", s_st,   1'b1);
        chk("t2_ext_gnt", s_egnt, 1'b1);
        run_cycle();
        chk("t2_cnt_clr", s_sc, 4'd0);
        idle_inputs();
        repeat (3) run_cycle();

        // ---- store then load, back to back ----
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0020; bus.cpu_wdata = 16'h1234;
        run_cycle();
        bus.cpu_we = 0; bus.cpu_wdata = '0;
        run_cycle();
        chk("t3_mem_we_st", s_mwe, 1'b1);
        idle_inputs();
        run_cycle();
        chk("t3_mem_we_ld", s_mwe, 1'b0);
        chk("t3_no_ext_rv", s_erv, 1'b0);
        run_cycle();
        chk("t3_rvalid", s_crv, 1'b1);
        chk("t3_rdata",  s_crd, 16'h1234);
        run_cycle();

        // ---- reset while an ext load is in flight ----
        bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 16'h0044;
        run_cycle();
        idle_inputs();
        reset = 1'b0;
        model_reset();
        #1;
        chk("t4_mem_en_rst", bus.mem_en, 1'b0);
        #1;
        run_cycle();
        reset = 1'b1;
        egnt_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            if (s_erv) egnt_cnt++;
        end
        chk("t4_no_ext_rvalid", egnt_cnt, 0);

        // ---- locked cpu ownership vs ext ----
        bus.cpu_req = 1; bus.cpu_lock = 1; bus.cpu_addr = 16'h0050;
        run_cycle();
        bus.ext_req = 1; bus.ext_addr = 16'h0051;
        first_egnt = -1; egnt_cnt = 0; st_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            if (s_egnt) begin
                egnt_cnt++;
                if (first_egnt < 0) first_egnt = i;
            end
            if (s_st) st_cnt++;
        end
`ifdef DMEM_ARB_LOCK_EN
        chk("t5_no_ext_gnt", egnt_cnt, 0);
        chk("t5_no_starved", st_cnt, 0);
        bus.cpu_lock = 0;
        run_cycle();
        chk("t5_ext_after_unlock", s_egnt, 1'b1);
`else
        chk("t6_first_ext_gnt", first_egnt, LIMIT);
        chk("t6_starved_count", st_cnt, 2);
`endif
        idle_inputs();
        repeat (3) run_cycle();

        // ---- randomized traffic ----
        for (int i = 0; i < 400; i++) begin
            bus.cpu_req   = ($urandom_range(0, 99) < 60);
            bus.cpu_we    = $urandom_range(0, 1) != 0;
            bus.cpu_addr  = 16'h0040 + 16'($urandom_range(0, 15));
            bus.cpu_wdata = 16'($urandom);
            bus.cpu_lock  = ($urandom_range(0, 99) < 30);
            bus.ext_req   = ($urandom_range(0, 99) < 60);
            bus.ext_we    = $urandom_range(0, 1) != 0;
            bus.ext_addr  = 16'h0040 + 16'($urandom_range(0, 15));
            bus.ext_wdata = 16'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                model_reset();
                run_cycle();
                reset = 1'b1;
            end else begin
                run_cycle();
            end
        end
        idle_inputs();
        repeat (3) run_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
